// File: rtl/camera_capture.sv
// camera_capture: sensor capture front end in the p_clock domain.
// Packs BYTES_PER_PIXEL sensor bytes into one pixel and tags each pixel with its x/y
// position. Emits frame and line strobes, and checks line length and line count
// against the configured geometry. Partial frames seen after reset are rejected.
module camera_capture #(
  parameter int DATA_W          = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int X_W             = 10,
  parameter int Y_W             = 9
) (
  input  logic                              p_clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              vsync,
  input  logic                              href,
  input  logic [DATA_W-1:0]                 p_data,
  output logic [DATA_W*BYTES_PER_PIXEL-1:0] pixel_data,
  output logic                              pixel_valid,
  output logic [X_W-1:0]                    pixel_x,
  output logic [Y_W-1:0]                    pixel_y,
  output logic                              frame_start,
  output logic                              frame_done,
  output logic                              line_done,
  output logic                              line_err,
  output logic                              frame_err
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIXEL;
  localparam int BC_W  = 2;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BYTES_PER_PIXEL - 1);
  localparam logic [X_W-1:0]  H_EXP   = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]  V_EXP   = Y_W'(V_ACTIVE);

  typedef enum logic [1:0] {
    S_SYNC,
    S_VBLANK,
    S_ACTIVE
  } state_t;

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  shreg_q, shreg_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [X_W-1:0]    col_q, col_d;
  logic [Y_W-1:0]    row_q, row_d;
  logic              in_line_q, in_line_d;
  logic              pend_q, pend_d;

  logic [PIX_W-1:0]  pixel_data_q, pixel_data_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [X_W-1:0]    pixel_x_q, pixel_x_d;
  logic [Y_W-1:0]    pixel_y_q, pixel_y_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              line_done_q, line_done_d;
  logic              line_err_q, line_err_d;
  logic              frame_err_q, frame_err_d;

  logic              pack;
  logic              line_end;
  logic [X_W-1:0]    col_total;
  logic [Y_W-1:0]    row_total;

  function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
    return (&v) ? v : v + X_W'(1);
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    return (&v) ? v : v + Y_W'(1);
  endfunction

  // Next-state, packing, counters and registered-output values.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    byte_cnt_d    = byte_cnt_q;
    col_d         = col_q;
    row_d         = row_q;
    in_line_d     = in_line_q;
    pend_d        = 1'b0;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    line_done_d   = 1'b0;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;

    // A line is open once a byte has been packed in this frame. vsync rising closes it
    // even with href still high, so the closing line is counted before frame end.
    pack      = (state_q == S_ACTIVE) && !vsync && href;
    line_end  = (state_q == S_ACTIVE) && in_line_q && (!href || vsync);
    // The pixel completed on the previous edge is emitted now and still counts toward
    // the line length checked on this same edge.
    col_total = pend_q ? sat_inc_x(col_q) : col_q;
    row_total = line_end ? sat_inc_y(row_q) : row_q;

    if (pend_q) begin
      pixel_valid_d = 1'b1;
      pixel_data_d  = shreg_q;
      pixel_x_d     = col_q;
      pixel_y_d     = row_q;
      col_d         = sat_inc_x(col_q);
    end

    unique case (state_q)
      S_SYNC: begin
        if (vsync) state_d = S_VBLANK;
      end
      S_VBLANK: begin
        if (!vsync && enable) begin
          state_d       = S_ACTIVE;
          frame_start_d = 1'b1;
          col_d         = '0;
          row_d         = '0;
          byte_cnt_d    = '0;
          in_line_d     = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (vsync) begin
          state_d      = S_VBLANK;
          frame_done_d = 1'b1;
          frame_err_d  = (row_total != V_EXP);
        end
      end
      default: state_d = S_SYNC;
    endcase

    if (pack) begin
      shreg_d   = (shreg_q << DATA_W) | PIX_W'(p_data);
      in_line_d = 1'b1;
      if (byte_cnt_q == BC_LAST) begin
        byte_cnt_d = '0;
        pend_d     = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + BC_W'(1);
      end
    end

    if (line_end) begin
      line_done_d = 1'b1;
      line_err_d  = (col_total != H_EXP) || (byte_cnt_q != '0);
      col_d       = '0;
      byte_cnt_d  = '0;
      row_d       = row_total;
      in_line_d   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge p_clock) begin
    if (reset) state_q <= S_SYNC;
    else       state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge p_clock) begin
    if (reset) begin
      shreg_q       <= '0;
      byte_cnt_q    <= '0;
      col_q         <= '0;
      row_q         <= '0;
      in_line_q     <= 1'b0;
      pend_q        <= 1'b0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_done_q   <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      shreg_q       <= shreg_d;
      byte_cnt_q    <= byte_cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      in_line_q     <= in_line_d;
      pend_q        <= pend_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_done_q   <= line_done_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign line_done   = line_done_q;
  assign line_err    = line_err_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture: three instances (2, 3 and 1 bytes per pixel, 4x2 geometry,
// 3-bit x and 2-bit y counters) share one sensor stream. A frame-level model predicts
// every strobe with its cycle, and a monitor matches DUT events against those queues.
module tb_camera_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, vs, hr;
  logic [7:0] pd;

  logic        pv [3];
  logic        fs [3];
  logic        fd [3];
  logic        ld [3];
  logic        le [3];
  logic        fe [3];
  logic [2:0]  px [3];
  logic [1:0]  py [3];
  logic [23:0] pdat [3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [63:0] q_pix  [3][$];
  logic [63:0] q_line [3][$];
  logic [63:0] q_frm  [3][$];

  typedef logic [7:0] bq_t [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int B = (g == 0) ? 2 : (g == 1) ? 3 : 1;
    logic [8*B-1:0] data;
    camera_capture #(
      .DATA_W(8), .BYTES_PER_PIXEL(B), .H_ACTIVE(4), .V_ACTIVE(2), .X_W(3), .Y_W(2)
    ) u_dut (
      .p_clock(clk), .reset(rst), .enable(en), .vsync(vs), .href(hr), .p_data(pd),
      .pixel_data(data), .pixel_valid(pv[g]), .pixel_x(px[g]), .pixel_y(py[g]),
      .frame_start(fs[g]), .frame_done(fd[g]), .line_done(ld[g]), .line_err(le[g]),
      .frame_err(fe[g])
    );
    assign pdat[g] = 24'(data);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int bpp(input int k);
    return (k == 0) ? 2 : (k == 1) ? 3 : 1;
  endfunction

  function automatic logic [63:0] enc_pix(input int c, input int y, input int x, input int d);
    return {16'(c), 8'(y), 8'(x), 32'(d)};
  endfunction

  function automatic logic [63:0] enc_line(input int c, input int err);
    return {32'(c), 32'(err)};
  endfunction

  function automatic logic [63:0] enc_frm(input int c, input int done, input int err, input int wl);
    return {32'(c), 29'd0, 1'(done), 1'(err), 1'(wl)};
  endfunction

  function automatic int pick_len();
    int unsigned r;
    r = $urandom_range(0, 6);
    case (r)
      0: return 4;
      1: return 6;
      2: return 7;
      3: return 8;
      4: return 12;
      5: return 20;
      default: return int'($urandom_range(1, 20));
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pixels and line result for line l whose first byte is sampled at edge e0.
  task automatic push_line(input int l, input bq_t b, input int e0);
    int n, bb, npix, d, err;
    n = b.size();
    for (int k = 0; k < 3; k++) begin
      bb   = bpp(k);
      npix = n / bb;
      for (int p = 0; p < npix; p++) begin
        d = 0;
        for (int j = 0; j < bb; j++) d = (d << 8) | int'(b[p*bb+j]);
        q_pix[k].push_back(enc_pix(e0 + p*bb + bb, (l > 3) ? 3 : l, (p > 7) ? 7 : p, d));
      end
      err = (((npix > 7) ? 7 : npix) != 4 || (n % bb) != 0) ? 1 : 0;
      q_line[k].push_back(enc_line(e0 + n, err));
    end
  endtask

  task automatic push_frm(input int c, input int done, input int err, input int wl);
    for (int k = 0; k < 3; k++) q_frm[k].push_back(enc_frm(c, done, err, wl));
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s_d%0d", tag, k),
          64'({pv[k], fs[k], fd[k], ld[k], le[k], fe[k], px[k], py[k], pdat[k]}), 64'd0);
  endtask

  // One frame: blanking, vsync fall, nl lines, close. len=0 picks random lengths;
  // stp!=0 gives bytes base+i*stp. last_mode: 0 href falls before vsync rises,
  // 1 href falls on the vsync rise edge, 2 href still high at the vsync rise.
  task automatic frame(input bit en_f, input int nl, input int len, input int base,
                       input int stp, input int last_mode);
    bq_t b;
    int  n, mode, e0;
    bit  closed;
    vs = 1'b1; hr = 1'b0; en = en_f;
    step(); step();
    vs = 1'b0;
    if (en_f) push_frm(cyc + 1, 0, 0, 0);
    step();
    if (en_f) en = 1'($urandom_range(0, 1));
    repeat ($urandom_range(1, 2)) step();
    closed = 1'b0;
    for (int l = 0; l < nl; l++) begin
      n    = (len > 0) ? len : pick_len();
      mode = (l == nl - 1) ? last_mode : 0;
      b    = {};
      for (int i = 0; i < n; i++) b.push_back((stp != 0) ? 8'(base + i*stp) : 8'($urandom));
      e0 = cyc + 1;
      if (en_f) push_line(l, b, e0);
      for (int i = 0; i < n; i++) begin
        hr = 1'b1; pd = b[i];
        step();
      end
      if (mode == 0) begin
        hr = 1'b0; pd = 8'($urandom);
        repeat ($urandom_range(1, 3)) step();
      end else begin
        if (en_f) push_frm(cyc + 1, 1, (nl != 2) ? 1 : 0, 1);
        vs = 1'b1; hr = (mode == 2); pd = 8'($urandom);
        step();
        hr = 1'b0;
        closed = 1'b1;
      end
    end
    if (!closed) begin
      if (en_f) push_frm(cyc + 1, 1, (nl != 2) ? 1 : 0, 0);
      vs = 1'b1;
      step();
    end
    step();
  endtask

  // Reset in the middle of a line, then href activity with vsync low that must be ignored.
  task automatic reset_mid_line();
    bq_t b;
    int  e0;
    vs = 1'b1; hr = 1'b0; en = 1'b1;
    step(); step();
    vs = 1'b0;
    push_frm(cyc + 1, 0, 0, 0);
    step(); step();
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    e0 = cyc + 1;
    push_line(0, b, e0);
    for (int i = 0; i < 3; i++) begin
      hr = 1'b1; pd = b[i];
      step();
    end
    rst = 1'b1; pd = b[3];
    step();
    chk_zero("midreset");
    for (int k = 0; k < 3; k++) begin
      q_pix[k].delete();
      q_line[k].delete();
      q_frm[k].delete();
    end
    rst = 1'b0;
    repeat (3) begin
      hr = 1'b1;
      repeat (5) begin
        pd = 8'($urandom);
        step();
      end
      hr = 1'b0;
      repeat (2) step();
    end
  endtask

  // Match every observed strobe against the oldest expected event of its kind.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pv[k]) begin
        chk($sformatf("pix_expected_d%0d", k), 64'(q_pix[k].size() != 0), 64'd1);
        if (q_pix[k].size() != 0)
          chk($sformatf("pix_d%0d", k),
              enc_pix(cyc, int'(py[k]), int'(px[k]), int'(pdat[k])), q_pix[k].pop_front());
      end
      if (ld[k]) begin
        chk($sformatf("line_expected_d%0d", k), 64'(q_line[k].size() != 0), 64'd1);
        if (q_line[k].size() != 0)
          chk($sformatf("line_d%0d", k), enc_line(cyc, int'(le[k])), q_line[k].pop_front());
      end
      if (fs[k] || fd[k]) begin
        chk($sformatf("frame_expected_d%0d", k), 64'(q_frm[k].size() != 0), 64'd1);
        if (q_frm[k].size() != 0)
          chk($sformatf("frame_d%0d", k),
              enc_frm(cyc, int'(fd[k]), int'(fe[k]), int'(ld[k])), q_frm[k].pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; vs = 1'b1; hr = 1'b0; en = 1'b0; pd = 8'h00;
    repeat (3) step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    frame(1'b1, 2, 8, 1, 1, 0);          // bytes 01..08 on two lines
    frame(1'b1, 2, 7, 0, 0, 0);          // 7-byte lines, partial pixel dropped
    frame(1'b1, 1, 8, 3, 5, 1);          // single line, href falls with vsync rise
    frame(1'b1, 1, 6, 0, 0, 2);          // single line, href high at vsync rise
    frame(1'b1, 1, 12, 'hAA, 'h11, 0);   // AA BB CC ... packing and latency
    frame(1'b1, 5, 20, 0, 0, 0);         // x and y counters saturate
    frame(1'b0, 2, 8, 0, 0, 0);          // disabled frame
    reset_mid_line();
    frame(1'b1, 2, 8, 0, 0, 0);

    for (int f = 0; f < 24; f++)
      frame($urandom_range(0, 3) != 0, int'($urandom_range(0, 5)), 0, 0, 0,
            int'($urandom_range(0, 2)));

    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("leftover_pix_d%0d", k), 64'(q_pix[k].size()), 64'd0);
      chk($sformatf("leftover_line_d%0d", k), 64'(q_line[k].size()), 64'd0);
      chk($sformatf("leftover_frame_d%0d", k), 64'(q_frm[k].size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
